// File: rtl/divider_4bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Optional DIV_EARLY_EXIT_EN: when dividend < divisor, go straight to DONE and skip CALC.
module divider_4bit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pr, wd, dvs;
    logic [WIDTH-1:0] pr_nxt, wd_nxt;
    logic [WIDTH:0]   sh_pr, trial;
    logic             accept, zero_div, early, last;

    assign accept   = start && (state == IDLE || state == DONE);
    assign zero_div = (divisor == '0);
    assign last     = (cnt == CW'(WIDTH - 1));
`ifdef DIV_EARLY_EXIT_EN
    assign early    = !zero_div && (dividend < divisor);
`else
    assign early    = 1'b0;
`endif

    // The partial remainder is always below the divisor, so the shifted value
    // is below 2*divisor and WIDTH+1 bits are enough for the trial subtraction.
    assign sh_pr  = {pr, wd[WIDTH-1]};
    assign trial  = sh_pr - {1'b0, dvs};
    assign pr_nxt = trial[WIDTH] ? sh_pr[WIDTH-1:0] : trial[WIDTH-1:0];
    assign wd_nxt = {wd[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (zero_div || early) ? DONE : CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    if (start) state_nxt = (zero_div || early) ? DONE : CALC;
                     else       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pr          <= '0;
            wd          <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else if (early) begin
                quotient    <= '0;
                remainder   <= dividend;
                div_by_zero <= 1'b0;
            end else begin
                wd  <= dividend;
                dvs <= divisor;
                pr  <= '0;
                cnt <= '0;
            end
        end else if (state == CALC) begin
            pr  <= pr_nxt;
            wd  <= wd_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                quotient    <= wd_nxt;
                remainder   <= pr_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_divider_4bit_seq.sv
// Directed bench for divider_4bit_seq: handshake timing, zero divisor, reset abort, full sweep.
module tb_divider_4bit_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int errors = 0;
    int checks = 0;
    int lat, busy_cnt, first_busy, got_done;
    int exp_small_lat, exp_small_busy;

    divider_4bit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands and pulse start across one rising edge.
    task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count negedges after the accepting edge until done; optionally pulse junk starts during CALC.
    task automatic wait_done(input bit noise, output int l, output int bc, output int fb, output int gd);
        l = 0; bc = 0; fb = 0; gd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            l++;
            if (l == 1) fb = int'(busy);
            if (busy) bc++;
            if (noise && busy) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                gd = 1;
                break;
            end
        end
    endtask

    initial begin
`ifdef DIV_EARLY_EXIT_EN
        exp_small_lat = 1; exp_small_busy = 0;
`else
        exp_small_lat = W + 1; exp_small_busy = W;
`endif
        // reset state
        #12;
        chk("rst_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 13 / 3
        start_op(4'd13, 4'd3);
        wait_done(1'b0, lat, busy_cnt, first_busy, got_done);
        chk("13/3_done", got_done, 1);
        chk("13/3_lat", lat, W + 1);
        chk("13/3_busy_cycles", busy_cnt, W);
        chk("13/3_result", {div_by_zero, quotient, remainder}, {1'b0, 4'd4, 4'd1});
        @(negedge clk);
        chk("13/3_done_pulse_one", {done, busy}, 2'b00);
        chk("13/3_held", {quotient, remainder}, {4'd4, 4'd1});

        // 15 / 15 then back-to-back 15 / 1 in the DONE cycle
        start_op(4'd15, 4'd15);
        wait_done(1'b0, lat, busy_cnt, first_busy, got_done);
        chk("15/15_done", got_done, 1);
        chk("15/15_result", {div_by_zero, quotient, remainder}, {1'b0, 4'd1, 4'd0});
        start_op(4'd15, 4'd1);
        wait_done(1'b0, lat, busy_cnt, first_busy, got_done);
        chk("b2b_busy_after_done", first_busy, 1);
        chk("b2b_lat", lat, W + 1);
        chk("15/1_result", {div_by_zero, quotient, remainder}, {1'b0, 4'd15, 4'd0});
        @(negedge clk);

        // 1 / 5: dividend below divisor
        start_op(4'd1, 4'd5);
        wait_done(1'b0, lat, busy_cnt, first_busy, got_done);
        chk("1/5_done", got_done, 1);
        chk("1/5_lat", lat, exp_small_lat);
        chk("1/5_busy_cycles", busy_cnt, exp_small_busy);
        chk("1/5_result", {div_by_zero, quotient, remainder}, {1'b0, 4'd0, 4'd1});
        @(negedge clk);

        // 5 / 0
        start_op(4'd5, 4'd0);
        wait_done(1'b0, lat, busy_cnt, first_busy, got_done);
        chk("5/0_done", got_done, 1);
        chk("5/0_lat", lat, 1);
        chk("5/0_busy_cycles", busy_cnt, 0);
        chk("5/0_result", {div_by_zero, quotient, remainder}, {1'b1, 4'hF, 4'd5});
        @(negedge clk);
        chk("5/0_held_idle", {done, div_by_zero, quotient, remainder}, {1'b0, 1'b1, 4'hF, 4'd5});

        // 9 / 2 aborted by reset in its second CALC cycle
        start_op(4'd9, 4'd2);
        @(negedge clk);
        chk("abort_busy1", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_cleared", {busy, done, div_by_zero, quotient, remainder}, '0);
        got_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        chk("abort_no_done", got_done, 0);
        start_op(4'd9, 4'd2);
        wait_done(1'b0, lat, busy_cnt, first_busy, got_done);
        chk("9/2_done", got_done, 1);
        chk("9/2_result", {div_by_zero, quotient, remainder}, {1'b0, 4'd4, 4'd1});
        @(negedge clk);

        // all operand pairs, back to back, with start noise during CALC
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 16; dv++) begin
                logic [W-1:0] eq, er;
                logic         ez;
                int           el;
                if (dv == 0) begin
                    eq = 4'hF; er = W'(dd); ez = 1'b1; el = 1;
                end else begin
                    eq = W'(dd / dv); er = W'(dd % dv); ez = 1'b0;
                    el = (dd < dv) ? exp_small_lat : W + 1;
                end
                start_op(W'(dd), W'(dv));
                wait_done(1'b1, lat, busy_cnt, first_busy, got_done);
                chk($sformatf("sweep_%0d/%0d_result", dd, dv),
                    {got_done[0], ez == div_by_zero, quotient, remainder}, {1'b1, 1'b1, eq, er});
                chk($sformatf("sweep_%0d/%0d_lat", dd, dv), lat, el);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
